hyperbus_r_chan: RTL and testbench
==================================

HYPERBUS_R_CHAN -- requirements
Module: hyperbus_r_chan

Interface
REQ-001 SHALL have parameter AxiDataWidth, default 64: R data width in bits.
REQ-002 SHALL have parameter AxiIdWidth, default 4: AXI ID width.
REQ-003 SHALL have parameter AxiLenWidth, default 8: burst length field width (beats minus one).
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 SHALL have port: clk_i  in  1  clock, all logic on rising edge.
REQ-006 SHALL have port: rst_ni  in  1  synchronous active-low reset.
REQ-007 SHALL have ports: cmd_valid_i in 1, cmd_ready_o out 1: read-command handshake.
REQ-008 SHALL have ports: cmd_id_i in AxiIdWidth, cmd_len_i in AxiLenWidth: ID and AXI len of the accepted read.
REQ-009 SHALL have ports: beat_valid_i in 1, beat_ready_o out 1: data-beat handshake from the splitter.
REQ-010 SHALL have ports: beat_data_i in AxiDataWidth, beat_error_i in 1, beat_last_i in 1: beat payload.
REQ-011 SHALL have ports: r_valid_o out 1, r_ready_i in 1, r_data_o out AxiDataWidth, r_id_o out AxiIdWidth, r_resp_o out 2, r_last_o out 1: AXI R channel.
REQ-012 SHALL have port: mismatch_o  out  1: one-cycle pulse when splitter last disagrees with the beat count.

Function
REQ-013 SHALL implement FSM states Idle, Stream, Pad, Drop.
REQ-014 SHALL assert cmd_ready_o only in Idle; a cmd handshake latches id, loads beats_left = cmd_len_i, and moves to Stream.
REQ-015 SHALL buffer beats in a 2-entry FIFO; beat_ready_o = 1 in Stream only when FIFO occupancy < 2 (registered occupancy; a same-cycle pop does not free space).
REQ-016 SHALL present a beat on R no earlier than the cycle after it is accepted (1-cycle minimum latency, no combinational path from beat_* or r_ready_i to any output).
REQ-017 SHALL drive r_resp_o = 2'b10 (SLVERR) for beats with error set, 2'b00 (OKAY) otherwise; r_id_o = latched id.
REQ-018 SHALL set r_last_o on the pushed entry when beats_left == 0, independent of beat_last_i.
REQ-019 SHALL decrement beats_left on each push; on the final push (beats_left == 0) with beat_last_i = 1 go to Idle.
REQ-020 SHALL, on the final push with beat_last_i = 0, pulse mismatch_o and go to Drop.
REQ-021 SHALL in Drop hold beat_ready_o = 1, discard beats, and return to Idle on an accepted beat with beat_last_i = 1.
REQ-022 SHALL, on a push with beat_last_i = 1 and beats_left != 0, pulse mismatch_o and go to Pad.
REQ-023 SHALL in Pad hold beat_ready_o = 0 and push synthetic beats (data 0, SLVERR) while FIFO has space, marking the last with r_last_o, then go to Idle.
REQ-024 SHALL allow a new cmd in Idle while the FIFO still drains; the ID travels per entry.
REQ-025 SHALL hold r_valid_o and all R payload stable until r_ready_i.

Reset
REQ-026 SHALL on rst_ni = 0 at a clock edge: state Idle, FIFO empty, beats_left 0, latched id 0.
REQ-027 SHALL drive all outputs 0 during and after reset, except cmd_ready_o = 1 after reset release.
REQ-028 SHALL discard buffered beats on mid-burst reset, with no R beat emitted for the aborted burst.

Structure
REQ-029 SHALL take the state enum and RESP_OKAY/RESP_SLVERR constants from hyperbus_pkg.
REQ-030 SHALL instantiate the 2-entry buffer as sub-module hyperbus_r_skid (payload: data, id, resp, last).

Verification
REQ-031 SHALL cover: cmd len=3, id=5, 4 clean beats, last on 4th, r_ready=1 -> 4 R beats OKAY id 5, r_last on 4th only, no mismatch.
REQ-032 SHALL cover: len=1, r_ready=0 for 5 cycles -> beat_ready drops after 2 accepted beats, data held stable, both delivered in order once r_ready=1.
REQ-033 SHALL cover: len=3, splitter last on beat 2 -> mismatch pulse, beats 1-2 real, beats 3-4 data 0 SLVERR, r_last on 4th.
REQ-034 SHALL cover: len=1, splitter sends 4 beats, last on 4th -> mismatch pulse, 2 R beats, r_last on 2nd, beats 3-4 consumed and dropped, cmd_ready then 1.
REQ-035 SHALL cover: beat 2 of len=2 with error=1 -> r_resp 2'b10 on that beat only.
REQ-036 SHALL cover: reset asserted after 1 of 4 beats -> no R beat afterwards, all outputs at reset values.

Source files
------------

// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the HyperBus read-return path.
package hyperbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_PAD    = 2'd2,
    ST_DROP   = 2'd3
  } r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [1:0] beat_resp(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/hyperbus_r_skid.sv
// Two-entry registered buffer between the read FSM and the AXI R channel.
// Outputs come straight from storage, so no input reaches an output in the same cycle.
module hyperbus_r_skid
  import hyperbus_pkg::*;
#(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] push_data_i,
  input  logic [IdWidth-1:0]   push_id_i,
  input  logic [1:0]           push_resp_i,
  input  logic                 push_last_i,
  output logic                 space_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic [IdWidth-1:0]   id_o,
  output logic [1:0]           resp_o,
  output logic                 last_o
);

  logic [DataWidth-1:0] data_q [2];
  logic [IdWidth-1:0]   id_q   [2];
  logic [1:0]           resp_q [2];
  logic                 last_q [2];
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [1:0]           count_q;
  logic                 pop;

  // Space is judged on the registered count only; a pop in this cycle frees
  // a slot for the next cycle, keeping ready free of any r_ready path.
  assign space_o = (count_q != 2'd2);
  assign valid_o = (count_q != 2'd0);
  assign pop     = valid_o && ready_i;

  assign data_o = valid_o ? data_q[rd_ptr_q] : '0;
  assign id_o   = valid_o ? id_q[rd_ptr_q]   : '0;
  assign resp_o = valid_o ? resp_q[rd_ptr_q] : RESP_OKAY;
  assign last_o = valid_o ? last_q[rd_ptr_q] : 1'b0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        id_q[i]   <= '0;
        resp_q[i] <= RESP_OKAY;
        last_q[i] <= 1'b0;
      end
    end else begin
      if (push_i) begin
        data_q[wr_ptr_q] <= push_data_i;
        id_q[wr_ptr_q]   <= push_id_i;
        resp_q[wr_ptr_q] <= push_resp_i;
        last_q[wr_ptr_q] <= push_last_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/hyperbus_r_chan.sv
// Read-data return channel: turns splitter beats into AXI R beats, enforcing the
// burst length from the command and padding or dropping when the splitter disagrees.
//
// Handshakes (cmd, beat, r) are strict valid/ready: a transfer happens on a rising
// edge where both are high; valid never waits on ready, and payload is held while
// valid is high and ready low.
module hyperbus_r_chan
  import hyperbus_pkg::*;
#(
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AxiLenWidth  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [AxiIdWidth-1:0]   cmd_id_i,
  input  logic [AxiLenWidth-1:0]  cmd_len_i,
  input  logic                    beat_valid_i,
  output logic                    beat_ready_o,
  input  logic [AxiDataWidth-1:0] beat_data_i,
  input  logic                    beat_error_i,
  input  logic                    beat_last_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [AxiDataWidth-1:0] r_data_o,
  output logic [AxiIdWidth-1:0]   r_id_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o,
  output logic                    mismatch_o
);

  r_state_e                state_q, state_d;
  logic [AxiLenWidth-1:0]  beats_left_q, beats_left_d;
  logic [AxiIdWidth-1:0]   id_q, id_d;
  logic                    mismatch_q, mismatch_d;

  logic                    push;
  logic [AxiDataWidth-1:0] push_data;
  logic [1:0]              push_resp;
  logic                    push_last;
  logic                    space;
  logic                    cmd_ready;
  logic                    beat_ready;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      beats_left_q <= '0;
      id_q         <= '0;
      mismatch_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      id_q         <= id_d;
      mismatch_q   <= mismatch_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    id_d         = id_q;
    mismatch_d   = 1'b0;
    push         = 1'b0;
    push_data    = '0;
    push_resp    = RESP_OKAY;
    push_last    = 1'b0;
    cmd_ready    = 1'b0;
    beat_ready   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid_i) begin
          id_d         = cmd_id_i;
          beats_left_d = cmd_len_i;
          state_d      = ST_STREAM;
        end
      end

      ST_STREAM: begin
        beat_ready = space;
        if (beat_valid_i && space) begin
          push      = 1'b1;
          push_data = beat_data_i;
          push_resp = beat_resp(beat_error_i);
          // r_last follows our own count, never the splitter's flag.
          push_last = (beats_left_q == '0);
          if (beats_left_q == '0) begin
            if (beat_last_i) begin
              state_d = ST_IDLE;
            end else begin
              mismatch_d = 1'b1;
              state_d    = ST_DROP;
            end
          end else begin
            beats_left_d = beats_left_q - AxiLenWidth'(1);
            if (beat_last_i) begin
              mismatch_d = 1'b1;
              state_d    = ST_PAD;
            end
          end
        end
      end

      ST_PAD: begin
        if (space) begin
          push      = 1'b1;
          push_resp = RESP_SLVERR;
          push_last = (beats_left_q == '0);
          if (beats_left_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            beats_left_d = beats_left_q - AxiLenWidth'(1);
          end
        end
      end

      ST_DROP: begin
        beat_ready = 1'b1;
        if (beat_valid_i && beat_last_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Held low while reset is asserted so nothing is offered before the block is live.
  assign cmd_ready_o  = cmd_ready && rst_ni;
  assign beat_ready_o = beat_ready;
  assign mismatch_o   = mismatch_q;

  hyperbus_r_skid #(
    .DataWidth (AxiDataWidth),
    .IdWidth   (AxiIdWidth)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (push_data),
    .push_id_i   (id_q),
    .push_resp_i (push_resp),
    .push_last_i (push_last),
    .space_o     (space),
    .valid_o     (r_valid_o),
    .ready_i     (r_ready_i),
    .data_o      (r_data_o),
    .id_o        (r_id_o),
    .resp_o      (r_resp_o),
    .last_o      (r_last_o)
  );

endmodule

// File: tb/tb_hyperbus_r_chan.sv
// Directed self-checking bench for hyperbus_r_chan: clean bursts, backpressure,
// short and long splitter bursts, error beats and mid-burst reset.
module tb_hyperbus_r_chan;

  localparam int DW = 64;
  localparam int IW = 4;
  localparam int LW = 8;
  localparam int EW = DW + IW + 2 + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [IW-1:0] cmd_id;
  logic [LW-1:0] cmd_len;
  logic          beat_valid;
  logic          beat_ready;
  logic [DW-1:0] beat_data;
  logic          beat_error;
  logic          beat_last;
  logic          r_valid;
  logic          r_ready;
  logic [DW-1:0] r_data;
  logic [IW-1:0] r_id;
  logic [1:0]    r_resp;
  logic          r_last;
  logic          mismatch;

  hyperbus_r_chan #(
    .AxiDataWidth (DW),
    .AxiIdWidth   (IW),
    .AxiLenWidth  (LW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_id_i     (cmd_id),
    .cmd_len_i    (cmd_len),
    .beat_valid_i (beat_valid),
    .beat_ready_o (beat_ready),
    .beat_data_i  (beat_data),
    .beat_error_i (beat_error),
    .beat_last_i  (beat_last),
    .r_valid_o    (r_valid),
    .r_ready_i    (r_ready),
    .r_data_o     (r_data),
    .r_id_o       (r_id),
    .r_resp_o     (r_resp),
    .r_last_o     (r_last),
    .mismatch_o   (mismatch)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int mismatch_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void expect_beat(input logic [DW-1:0] d, input logic [IW-1:0] id,
                                      input logic [1:0] resp, input logic last);
    exp_q.push_back({d, id, resp, last});
  endfunction

  // scoreboard: R transfers and mismatch pulses sampled on the falling edge
  always @(negedge clk) begin
    if (mismatch === 1'b1) mismatch_cnt++;
    if (r_valid === 1'b1 && r_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("r_unexpected_valid", r_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("r_data", r_data, mon_e[EW-1 -: DW]);
        check_eq("r_id",   r_id,   mon_e[IW+2 -: IW]);
        check_eq("r_resp", r_resp, mon_e[2:1]);
        check_eq("r_last", r_last, mon_e[0]);
      end
    end
  end

  // driver tasks: called at posedge+1, return at posedge+1
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [IW-1:0] id, input logic [LW-1:0] len);
    logic acc;
    int t;
    cmd_valid = 1'b1; cmd_id = id; cmd_len = len;
    acc = 1'b0; t = 0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = cmd_ready;
      cycle();
      t++;
    end
    cmd_valid = 1'b0;
    check_eq("cmd_accept", acc, 1);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic err, input logic last);
    logic acc;
    int t;
    beat_valid = 1'b1; beat_data = d; beat_error = err; beat_last = last;
    acc = 1'b0; t = 0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = beat_ready;
      cycle();
      t++;
    end
    beat_valid = 1'b0; beat_error = 1'b0; beat_last = 1'b0;
    check_eq("beat_accept", acc, 1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || r_valid) && t < 200) begin
      cycle();
      t++;
    end
    check_eq("drain_done", (exp_q.size() == 0) && !r_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; r_ready = 1'b0;
    cmd_valid = 1'b0; cmd_id = '0; cmd_len = '0;
    beat_valid = 1'b0; beat_data = '0; beat_error = 1'b0; beat_last = 1'b0;
    repeat (3) cycle();

    // reset state
    check_eq("rst_cmd_ready",  cmd_ready,  0);
    check_eq("rst_beat_ready", beat_ready, 0);
    check_eq("rst_r_valid",    r_valid,    0);
    check_eq("rst_r_data",     r_data,     0);
    check_eq("rst_r_last",     r_last,     0);
    check_eq("rst_mismatch",   mismatch,   0);
    rst_n = 1'b1;
    cycle();
    check_eq("post_rst_cmd_ready", cmd_ready, 1);
    check_eq("post_rst_r_valid",   r_valid,   0);
    r_ready = 1'b1;

    // clean burst: len=3, id=5, last on 4th
    mismatch_cnt = 0;
    for (int i = 0; i < 4; i++) expect_beat(64'h1111_0000_0000_0000 + 64'(i), 4'd5, 2'b00, i == 3);
    send_cmd(4'd5, 8'd3);
    for (int i = 0; i < 4; i++) send_beat(64'h1111_0000_0000_0000 + 64'(i), 1'b0, i == 3);
    wait_drain();
    check_eq("t1_mismatch_cnt", mismatch_cnt, 0);
    check_eq("t1_cmd_ready", cmd_ready, 1);

    // backpressure: len=1 with r_ready low, then a new cmd while the buffer is full
    r_ready = 1'b0;
    expect_beat(64'h2222_0000_0000_00A0, 4'd2, 2'b00, 1'b0);
    expect_beat(64'h2222_0000_0000_00A1, 4'd2, 2'b00, 1'b1);
    send_cmd(4'd2, 8'd1);
    send_beat(64'h2222_0000_0000_00A0, 1'b0, 1'b0);
    send_beat(64'h2222_0000_0000_00A1, 1'b0, 1'b1);
    check_eq("t2_beat_ready_full", beat_ready, 0);
    check_eq("t2_cmd_ready_idle",  cmd_ready,  1);
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_hold_valid", r_valid, 1);
      check_eq("t2_hold_data",  r_data,  64'h2222_0000_0000_00A0);
      check_eq("t2_hold_last",  r_last,  0);
      cycle();
    end
    send_cmd(4'd9, 8'd0);
    check_eq("t2_stream_full_ready", beat_ready, 0);
    expect_beat(64'h2222_0000_0000_00A2, 4'd9, 2'b00, 1'b1);
    r_ready = 1'b1;
    send_beat(64'h2222_0000_0000_00A2, 1'b0, 1'b1);
    wait_drain();
    check_eq("t2_mismatch_cnt", mismatch_cnt, 0);

    // short splitter burst: len=3, last on beat 2 -> two padded SLVERR beats
    mismatch_cnt = 0;
    expect_beat(64'h3333_0000_0000_00B0, 4'd3, 2'b00, 1'b0);
    expect_beat(64'h3333_0000_0000_00B1, 4'd3, 2'b00, 1'b0);
    expect_beat(64'h0,                   4'd3, 2'b10, 1'b0);
    expect_beat(64'h0,                   4'd3, 2'b10, 1'b1);
    send_cmd(4'd3, 8'd3);
    send_beat(64'h3333_0000_0000_00B0, 1'b0, 1'b0);
    send_beat(64'h3333_0000_0000_00B1, 1'b0, 1'b1);
    wait_drain();
    check_eq("t3_mismatch_cnt", mismatch_cnt, 1);
    check_eq("t3_cmd_ready", cmd_ready, 1);

    // long splitter burst: len=1, 4 beats -> extra beats dropped
    mismatch_cnt = 0;
    expect_beat(64'h4444_0000_0000_00C0, 4'd6, 2'b00, 1'b0);
    expect_beat(64'h4444_0000_0000_00C1, 4'd6, 2'b00, 1'b1);
    send_cmd(4'd6, 8'd1);
    for (int i = 0; i < 4; i++) send_beat(64'h4444_0000_0000_00C0 + 64'(i), 1'b0, i == 3);
    wait_drain();
    check_eq("t4_mismatch_cnt", mismatch_cnt, 1);
    check_eq("t4_cmd_ready", cmd_ready, 1);
    check_eq("t4_beat_ready_idle", beat_ready, 0);

    // error on beat 2 of len=2
    mismatch_cnt = 0;
    expect_beat(64'h5555_0000_0000_00D0, 4'hA, 2'b00, 1'b0);
    expect_beat(64'h5555_0000_0000_00D1, 4'hA, 2'b10, 1'b0);
    expect_beat(64'h5555_0000_0000_00D2, 4'hA, 2'b00, 1'b1);
    send_cmd(4'hA, 8'd2);
    send_beat(64'h5555_0000_0000_00D0, 1'b0, 1'b0);
    send_beat(64'h5555_0000_0000_00D1, 1'b1, 1'b0);
    send_beat(64'h5555_0000_0000_00D2, 1'b0, 1'b1);
    wait_drain();
    check_eq("t5_mismatch_cnt", mismatch_cnt, 0);

    // reset after 1 of 4 beats: buffered beat discarded
    r_ready = 1'b0;
    send_cmd(4'd4, 8'd3);
    send_beat(64'h6666_0000_0000_00E0, 1'b0, 1'b0);
    check_eq("t6_buffered_valid", r_valid, 1);
    rst_n = 1'b0;
    cycle();
    r_ready = 1'b1;
    check_eq("t6_rst_r_valid",    r_valid,    0);
    check_eq("t6_rst_r_data",     r_data,     0);
    check_eq("t6_rst_r_id",       r_id,       0);
    check_eq("t6_rst_r_resp",     r_resp,     0);
    check_eq("t6_rst_r_last",     r_last,     0);
    check_eq("t6_rst_cmd_ready",  cmd_ready,  0);
    check_eq("t6_rst_beat_ready", beat_ready, 0);
    check_eq("t6_rst_mismatch",   mismatch,   0);
    cycle();
    rst_n = 1'b1;
    repeat (10) cycle();
    check_eq("t6_post_r_valid",   r_valid,   0);
    check_eq("t6_post_cmd_ready", cmd_ready, 1);
    check_eq("t6_exp_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
